// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-port arbiter: FSM encoding,
// requester-ID width helper and the burst beat counter width.
package fifo_pkg;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      BURST = 2'd1,
      GAP   = 2'd2
   } arb_state_t;

   // Beat counter holds 0..BURST_LEN-1 for BURST_LEN up to 16.
   localparam int BEAT_W = 4;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr, wrapping
// from N-1 back to 0. Purely combinational.
module rr_pick
   import fifo_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] rot_idx [N];

   // Index visited at each search offset, reduced modulo N without a divider.
   for (genvar k = 0; k < N; k++) begin : g_rot
      logic [IW:0] sum;
      assign sum        = {1'b0, ptr} + (IW+1)'(k);
      assign rot_idx[k] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
   end

   // Walk offsets in priority order and latch the first hit.
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!any && req[rot_idx[k]]) begin
            any                 = 1'b1;
            idx                 = rot_idx[k];
            onehot[rot_idx[k]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-domain arbiter sharing one async-FIFO read port among NUM_REQ
// consumers. Round-robin grants held for bursts of up to BURST_LEN pops,
// pop strobe gated by the synchronised empty flag, and a valid/ID pipeline
// aligned to the RAM read latency.
// Build option FIFO_RD_ARB_PRIO0_EN: requester 0 wins every arbitration it
// requests; the round-robin pointer then only moves after non-zero grants.
//
// state | meaning
// ------+---------------------------------------------------------------
// ARB   | idle, choose next owner when any request and FIFO not empty
// BURST | grant held, pop while owner requests and FIFO not empty
// GAP   | one-cycle handoff bubble, grant cleared, no pop
module fifo_rd_arbiter
   import fifo_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int BURST_LEN = 4,
   parameter int RD_LAT    = 1
) (
   input  logic                       clk_read,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       fifo_empty,
   output logic                       read_fr_stk,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       rd_valid,
   output logic [id_w(NUM_REQ)-1:0]   rd_id,
   output logic                       busy
);

   localparam int IW = id_w(NUM_REQ);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

   arb_state_t            state;
   logic [IW-1:0]         gidx;
   logic [IW-1:0]         ptr;
   logic [IW-1:0]         nxt_ptr;
   logic [BEAT_W-1:0]     beat;

   logic [NUM_REQ-1:0]    pick_oh;
   logic [IW-1:0]         pick_idx;
   logic                  pick_any;
   logic [NUM_REQ-1:0]    win_oh;
   logic [IW-1:0]         win_idx;
   logic                  win_any;

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

`ifdef FIFO_RD_ARB_PRIO0_EN
   // Requester 0 overrides the rotating choice whenever it asks.
   always_comb begin
      win_oh  = pick_oh;
      win_idx = pick_idx;
      win_any = pick_any;
      if (req[0]) begin
         win_oh  = NUM_REQ'(1);
         win_idx = '0;
         win_any = 1'b1;
      end
   end
`else
   assign win_oh  = pick_oh;
   assign win_idx = pick_idx;
   assign win_any = pick_any;
`endif

   assign nxt_ptr     = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
   assign read_fr_stk = (state == BURST) && req[gidx] && !fifo_empty;
   assign busy        = (state != ARB);

   // Arbitration FSM: owner selection, beat counting and pointer rotation.
   always_ff @(posedge clk_read or negedge rst) begin
      if (!rst) begin
         state <= ARB;
         grant <= '0;
         gidx  <= '0;
         beat  <= '0;
         ptr   <= '0;
      end else begin
         case (state)
            ARB: begin
               if (win_any && !fifo_empty) begin
                  grant <= win_oh;
                  gidx  <= win_idx;
                  beat  <= '0;
                  state <= BURST;
               end else begin
                  grant <= '0;
               end
            end
            BURST: begin
               if (read_fr_stk && (beat != LAST_BEAT)) begin
                  beat <= beat + 1'b1;
               end else begin
                  state <= GAP;
                  grant <= '0;
`ifdef FIFO_RD_ARB_PRIO0_EN
                  if (gidx != '0) ptr <= nxt_ptr;
`else
                  ptr <= nxt_ptr;
`endif
               end
            end
            GAP: begin
               state <= ARB;
               grant <= '0;
            end
            default: begin
               state <= ARB;
               grant <= '0;
            end
         endcase
      end
   end

   if (RD_LAT == 0) begin : g_lat0
      assign rd_valid = read_fr_stk;
      assign rd_id    = gidx;
   end else begin : g_pipe
      logic [RD_LAT-1:0] vpipe;
      logic [IW-1:0]     ipipe [RD_LAT];

      // Delay pop strobe and owner ID to line up with RAM read data.
      always_ff @(posedge clk_read or negedge rst) begin
         if (!rst) begin
            vpipe <= '0;
            for (int i = 0; i < RD_LAT; i++) ipipe[i] <= '0;
         end else begin
            vpipe[0] <= read_fr_stk;
            ipipe[0] <= gidx;
            for (int i = 1; i < RD_LAT; i++) begin
               vpipe[i] <= vpipe[i-1];
               ipipe[i] <= ipipe[i-1];
            end
         end
      end

      assign rd_valid = vpipe[RD_LAT-1];
      assign rd_id    = ipipe[RD_LAT-1];
   end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter (NUM_REQ=4, BURST_LEN=4, RD_LAT=2).
module tb_fifo_rd_arbiter;

   localparam int N   = 4;
   localparam int BL  = 4;
   localparam int LAT = 2;
`ifdef FIFO_RD_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif

   logic          clk_read = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  req = '0;
   logic          fifo_empty = 1'b1;
   logic          read_fr_stk;
   logic [N-1:0]  grant;
   logic          rd_valid;
   logic [1:0]    rd_id;
   logic          busy;

   fifo_rd_arbiter #(.NUM_REQ(N), .BURST_LEN(BL), .RD_LAT(LAT)) dut (
      .clk_read    (clk_read),
      .rst         (rst),
      .req         (req),
      .fifo_empty  (fifo_empty),
      .read_fr_stk (read_fr_stk),
      .grant       (grant),
      .rd_valid    (rd_valid),
      .rd_id       (rd_id),
      .busy        (busy)
   );

   always #5 clk_read = ~clk_read;

   int total = 0;
   int bad   = 0;

   // reference model: phase 0 = arbitrating, 1 = owner bursting, 2 = bubble
   int m_phase, m_owner, m_pops, m_ptr;
   bit past_v  [1:LAT];
   int past_id [1:LAT];

   int pops_seen, v_seen;
   bit last_pop;

   typedef struct {
      logic [N-1:0] req;
      logic         empty;
      logic [N-1:0] grant;
      logic         pop;
      logic         busy;
   } vec_t;
   vec_t vecs [21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_owner = 0; m_pops = 0; m_ptr = 0;
      for (int k = 1; k <= LAT; k++) begin
         past_v[k] = 1'b0; past_id[k] = 0;
      end
   endtask

   function automatic int model_pick(input logic [N-1:0] r);
      if (PRIO0 && r[0]) return 0;
      for (int k = 0; k < N; k++)
         if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return 0;
   endfunction

   // One clock: check at negedge against model (and optional table row),
   // advance the model, return just after the next posedge.
   task automatic step(input bit tab = 1'b0, input vec_t v = '{default: '0});
      bit           e_pop;
      logic [N-1:0] e_grant;
      @(negedge clk_read);
      e_pop   = (m_phase == 1) && req[m_owner] && !fifo_empty;
      e_grant = '0;
      if (m_phase == 1) e_grant[m_owner] = 1'b1;
      chk("grant", 32'(grant), 32'(e_grant));
      chk("pop", 32'(read_fr_stk), 32'(e_pop));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("rd_valid", 32'(rd_valid), 32'(past_v[LAT]));
      if (past_v[LAT]) chk("rd_id", 32'(rd_id), 32'(past_id[LAT]));
      if (tab) begin
         chk("tab_grant", 32'(grant), 32'(v.grant));
         chk("tab_pop", 32'(read_fr_stk), 32'(v.pop));
         chk("tab_busy", 32'(busy), 32'(v.busy));
      end
      last_pop = read_fr_stk;
      if (read_fr_stk === 1'b1) pops_seen++;
      if (rd_valid === 1'b1 && rd_id == 2'd0) v_seen++;
      for (int k = LAT; k > 1; k--) begin
         past_v[k] = past_v[k-1]; past_id[k] = past_id[k-1];
      end
      past_v[1] = e_pop; past_id[1] = m_owner;
      case (m_phase)
         0: if (req != '0 && !fifo_empty) begin
               m_owner = model_pick(req); m_pops = 0; m_phase = 1;
            end
         1: begin
               if (e_pop) m_pops++;
               if (!e_pop || m_pops == BL) begin
                  m_phase = 2;
                  if (!PRIO0 || m_owner != 0) m_ptr = (m_owner + 1) % N;
               end
            end
         default: m_phase = 0;
      endcase
      @(posedge clk_read);
      #1;
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b0; req = '0; fifo_empty = 1'b1;
      model_reset();
      #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_pop", 32'(read_fr_stk), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_id", 32'(rd_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clk_read);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      int cnt;
      logic [N-1:0] prev_g;
      logic [N-1:0] order [$];
      logic [N-1:0] exp_order [5];

      // req, empty -> grant, pop, busy
      vecs[0]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[1]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1};
      vecs[2]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1};
      vecs[3]  = '{4'b0010, 1'b1, 4'b0010, 1'b0, 1'b1};
      vecs[4]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1};
      vecs[5]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0};
      vecs[6]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[7]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1};
      vecs[8]  = '{4'b1100, 1'b0, 4'b0010, 1'b0, 1'b1};
      vecs[9]  = '{4'b1100, 1'b0, 4'b0000, 1'b0, 1'b1};
      vecs[10] = '{4'b1100, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[11] = '{4'b1100, 1'b0, 4'b0100, 1'b1, 1'b1};
      vecs[12] = '{4'b1000, 1'b0, 4'b0100, 1'b0, 1'b1};
      vecs[13] = '{4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1};
      vecs[14] = '{4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0};
      vecs[15] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1};
      vecs[16] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1};
      vecs[17] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1};
      vecs[18] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1};
      vecs[19] = '{4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1};
      vecs[20] = '{4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0};

      model_reset();
      @(posedge clk_read);
      do_reset();

      // single requester, FIFO holding 6 words
      cnt = 6; pops_seen = 0; v_seen = 0;
      req = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         fifo_empty = (cnt == 0);
         step();
         if (i == 0) chk("t1_first_grant", 32'(grant), 32'h1);
         if (last_pop) cnt--;
      end
      chk("t1_pops", 32'(pops_seen), 32'd6);
      chk("t1_valid_id0", 32'(v_seen), 32'd6);

      // empty mid-burst, then requester drop and full burst limit
      do_reset();
      for (int i = 0; i < 21; i++) begin
         req = vecs[i].req; fifo_empty = vecs[i].empty;
         step(1'b1, vecs[i]);
      end

      // full load rotation
      do_reset();
      req = 4'b1111; fifo_empty = 1'b0; prev_g = '0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (grant != '0 && prev_g == '0) order.push_back(grant);
         prev_g = grant;
      end
      if (PRIO0) exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
      else       exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      chk("t2_bursts", 32'(order.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (i < order.size()) chk("t2_order", 32'(order[i]), 32'(exp_order[i]));

      // requester 0 rising during a burst on 1
      do_reset();
      req = 4'b1110; fifo_empty = 1'b0;
      step(); step();
      req = 4'b1111;
      repeat (5) step();
      chk("t6_next_grant", 32'(grant), PRIO0 ? 32'h1 : 32'h4);

      // async reset mid-burst with pops in the valid pipe
      do_reset();
      req = 4'b0001; fifo_empty = 1'b0;
      repeat (4) step();
      #2;
      rst = 1'b0; req = '0;
      #1;
      chk("t5_grant", 32'(grant), 32'd0);
      chk("t5_pop", 32'(read_fr_stk), 32'd0);
      chk("t5_valid", 32'(rd_valid), 32'd0);
      chk("t5_id", 32'(rd_id), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      model_reset();
      repeat (2) step();
      rst = 1'b1;
      v_seen = 0;
      repeat (4) step();
      chk("t5_no_valid", 32'(v_seen), 32'd0);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         fifo_empty = ($urandom_range(0, 4) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
